// File: rtl/hdng_move_seq_if.sv
// Command, heading-sample and PID-drive signals for the heading move sequencer.
// The master is the navigation side; the slave is the sequencer itself.
interface hdng_move_seq_if;
    logic        cmd_vld;
    logic        cmd_type;
    logic [11:0] cmd_hdng;
    logic        cmd_rdy;
    logic        hdng_vld;
    logic        at_hdng;
    logic        stop_req;
    logic        moving;
    logic [11:0] dsrd_hdng;
    logic [10:0] frwrd_spd;
    logic        done;
    logic        busy;

    modport master (
        output cmd_vld, cmd_type, cmd_hdng, hdng_vld, at_hdng, stop_req,
        input  cmd_rdy, moving, dsrd_hdng, frwrd_spd, done, busy
    );

    modport slave (
        input  cmd_vld, cmd_type, cmd_hdng, hdng_vld, at_hdng, stop_req,
        output cmd_rdy, moving, dsrd_hdng, frwrd_spd, done, busy
    );
endinterface

// File: rtl/hdng_move_seq.sv
// Turn/move command sequencer driving the heading PID setpoint, enable and forward speed.
// Latency: accept -> moving in 1 clk; final qualifying heading sample -> done in 1 clk.
// Backpressure: cmd_rdy only in IDLE; commands offered while busy are dropped, not queued.
module hdng_move_seq #(
    parameter logic [10:0] SPD_INC = 11'd16,
    parameter logic [10:0] MAX_SPD = 11'd672,
    parameter int unsigned SETTLE  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    hdng_move_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        ACCEL = 2'd2,
        DECEL = 2'd3
    } state_t;

    localparam logic [10:0] DEC_STEP = SPD_INC << 1;
    localparam logic [2:0]  SETTLE_N = 3'(SETTLE);

    state_t      state_q, state_d;
    logic [11:0] dsrd_hdng_q, dsrd_hdng_d;
    logic [10:0] frwrd_spd_q, frwrd_spd_d;
    logic [2:0]  settle_cnt_q, settle_cnt_d;
    logic        done_q, done_d;

    logic [11:0] spd_sum;
    logic [2:0]  settle_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dsrd_hdng_q  <= 12'h000;
            frwrd_spd_q  <= 11'd0;
            settle_cnt_q <= 3'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dsrd_hdng_q  <= dsrd_hdng_d;
            frwrd_spd_q  <= frwrd_spd_d;
            settle_cnt_q <= settle_cnt_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dsrd_hdng_d  = dsrd_hdng_q;
        frwrd_spd_d  = frwrd_spd_q;
        settle_cnt_d = settle_cnt_q;
        done_d       = 1'b0;
        // One extra bit so the increment cannot wrap before saturation.
        spd_sum      = {1'b0, frwrd_spd_q} + {1'b0, SPD_INC};
        settle_inc   = settle_cnt_q + 3'd1;

        unique case (state_q)
            IDLE: begin
                frwrd_spd_d = 11'd0;
                if (bus.cmd_vld) begin
                    dsrd_hdng_d  = bus.cmd_hdng;
                    settle_cnt_d = 3'd0;
                    state_d      = bus.cmd_type ? ACCEL : TURN;
                end
            end
            TURN: begin
                if (bus.hdng_vld) begin
                    if (!bus.at_hdng) begin
                        settle_cnt_d = 3'd0;
                    end else if (settle_inc == SETTLE_N) begin
                        settle_cnt_d = 3'd0;
                        state_d      = IDLE;
                        done_d       = 1'b1;
                    end else begin
                        settle_cnt_d = settle_inc;
                    end
                end
            end
            ACCEL: begin
                // A stop request pre-empts the speed step in the same cycle.
                if (bus.stop_req) begin
                    state_d = DECEL;
                end else if (bus.hdng_vld) begin
                    frwrd_spd_d = (spd_sum > {1'b0, MAX_SPD}) ? MAX_SPD : spd_sum[10:0];
                end
            end
            DECEL: begin
                if (bus.hdng_vld) begin
                    if (frwrd_spd_q <= DEC_STEP) begin
                        frwrd_spd_d = 11'd0;
                        state_d     = IDLE;
                        done_d      = 1'b1;
                    end else begin
                        frwrd_spd_d = frwrd_spd_q - DEC_STEP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decode only the state register so reset acts on them at once.
    assign bus.cmd_rdy   = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.moving    = (state_q != IDLE);
    assign bus.dsrd_hdng = dsrd_hdng_q;
    assign bus.frwrd_spd = frwrd_spd_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_hdng_move_seq.sv
// Bench for hdng_move_seq: directed scenarios plus random traffic against a behavioural model.
module tb_hdng_move_seq;

    localparam int INC  = 16;
    localparam int MAXS = 672;
    localparam int SET  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hdng_move_seq_if bus();

    hdng_move_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: plain job description, not a state machine copy.
    bit          m_busy;
    bit          m_is_move;
    bit          m_stopping;
    bit          m_done;
    int          m_spd;
    int          m_run;
    logic [11:0] m_hdng;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_is_move = 0; m_stopping = 0; m_done = 0;
        m_spd = 0; m_run = 0; m_hdng = 12'h000;
    endtask

    // Apply one rising edge worth of behaviour using the inputs currently driven.
    task automatic model_edge();
        m_done = 0;
        if (!m_busy) begin
            if (bus.cmd_vld) begin
                m_hdng = bus.cmd_hdng;
                m_run = 0;
                m_busy = 1;
                m_is_move = bus.cmd_type;
                m_stopping = 0;
                m_spd = 0;
            end
        end else if (!m_is_move) begin
            if (bus.hdng_vld) begin
                m_run = bus.at_hdng ? m_run + 1 : 0;
                if (m_run >= SET) begin
                    m_run = 0; m_busy = 0; m_done = 1;
                end
            end
        end else if (!m_stopping) begin
            if (bus.stop_req) m_stopping = 1;
            else if (bus.hdng_vld) m_spd = (m_spd + INC > MAXS) ? MAXS : m_spd + INC;
        end else if (bus.hdng_vld) begin
            if (m_spd <= 2 * INC) begin
                m_spd = 0; m_busy = 0; m_done = 1;
            end else begin
                m_spd = m_spd - 2 * INC;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".moving"},    32'(bus.moving),    32'(m_busy));
        chk({tag, ".busy"},      32'(bus.busy),      32'(m_busy));
        chk({tag, ".cmd_rdy"},   32'(bus.cmd_rdy),   32'(!m_busy));
        chk({tag, ".frwrd_spd"}, 32'(bus.frwrd_spd), 32'(m_spd));
        chk({tag, ".dsrd_hdng"}, 32'(bus.dsrd_hdng), 32'(m_hdng));
        chk({tag, ".done"},      32'(bus.done),      32'(m_done));
    endtask

    // Called at a falling edge; drives inputs, advances the model, checks at the next falling edge.
    task automatic step(input string tag, input bit cv, input bit ct, input logic [11:0] ch,
                        input bit hv, input bit ah, input bit sr);
        bus.cmd_vld  = cv;
        bus.cmd_type = ct;
        bus.cmd_hdng = ch;
        bus.hdng_vld = hv;
        bus.at_hdng  = ah;
        bus.stop_req = sr;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_step(input string tag);
        step(tag, 0, 0, 12'h000, 0, 0, 0);
    endtask

    task automatic pulse(input string tag, input bit ah, input bit sr);
        step(tag, 0, 0, 12'h000, 1, ah, sr);
    endtask

    initial begin
        bit ap[4];
        int k;
        ap = '{1'b1, 1'b0, 1'b1, 1'b1};
        bus.cmd_vld = 0; bus.cmd_type = 0; bus.cmd_hdng = 12'h000;
        bus.hdng_vld = 0; bus.at_hdng = 0; bus.stop_req = 0;
        model_reset();

        @(negedge clk);
        check_all("rst");
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a move.
        step("t1", 1, 1, 12'h123, 0, 0, 0);
        repeat (6) pulse("t1", 0, 0);
        chk("t1_spd96", 32'(bus.frwrd_spd), 32'd96);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_moving", 32'(bus.moving), 32'd0);
        chk("t1_rst_spd", 32'(bus.frwrd_spd), 32'd0);
        chk("t1_rst_hdng", 32'(bus.dsrd_hdng), 32'd0);
        chk("t1_rst_rdy", 32'(bus.cmd_rdy), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all("t1_post");

        // Turn with a broken at-heading run.
        step("t2", 1, 0, 12'h3FF, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            pulse("t2", ap[i], 0);
            if (i < 3) begin
                chk("t2_no_done", 32'(bus.done), 32'd0);
                repeat (3) idle_step("t2");
            end
        end
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_hdng", 32'(bus.dsrd_hdng), 32'h3FF);

        // Long acceleration into saturation, then full deceleration.
        step("t3", 1, 1, 12'h050, 0, 0, 0);
        for (int i = 1; i <= 50; i++) begin
            pulse("t3", 0, 0);
            if (i == 41) chk("t3_spd41", 32'(bus.frwrd_spd), 32'd656);
            if (i == 42) chk("t3_spd42", 32'(bus.frwrd_spd), 32'd672);
        end
        chk("t3_spd50", 32'(bus.frwrd_spd), 32'd672);
        step("t3", 0, 0, 12'h000, 0, 0, 1);
        k = 0;
        while (!bus.done && k < 40) begin
            pulse("t3", 0, 0);
            k++;
        end
        chk("t3_done", 32'(bus.done), 32'd1);

        // Stop from 80.
        step("t4", 1, 1, 12'hF00, 0, 0, 0);
        repeat (5) pulse("t4", 0, 0);
        chk("t4_spd80", 32'(bus.frwrd_spd), 32'd80);
        step("t4", 0, 0, 12'h000, 0, 0, 1);
        chk("t4_hold80", 32'(bus.frwrd_spd), 32'd80);
        pulse("t4", 0, 0);
        chk("t4_spd48", 32'(bus.frwrd_spd), 32'd48);
        pulse("t4", 0, 0);
        chk("t4_spd16", 32'(bus.frwrd_spd), 32'd16);
        pulse("t4", 0, 0);
        chk("t4_spd0", 32'(bus.frwrd_spd), 32'd0);
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_moving", 32'(bus.moving), 32'd0);

        // Command while busy is dropped; accept in the done cycle.
        step("t5", 1, 0, 12'h100, 0, 0, 0);
        step("t5", 1, 1, 12'h200, 0, 0, 0);
        chk("t5_ignored", 32'(bus.dsrd_hdng), 32'h100);
        pulse("t5", 1, 0);
        pulse("t5", 1, 0);
        chk("t5_done", 32'(bus.done), 32'd1);
        step("t5", 1, 1, 12'h2AB, 0, 0, 0);
        chk("t5_new_hdng", 32'(bus.dsrd_hdng), 32'h2AB);
        chk("t5_new_moving", 32'(bus.moving), 32'd1);
        step("t5", 0, 0, 12'h000, 0, 0, 1);
        pulse("t5", 0, 0);

        // Stop and sample coincide.
        step("t6", 1, 1, 12'h010, 0, 0, 0);
        repeat (2) pulse("t6", 0, 0);
        pulse("t6", 0, 1);
        chk("t6_spd32", 32'(bus.frwrd_spd), 32'd32);
        chk("t6_busy", 32'(bus.busy), 32'd1);
        pulse("t6", 0, 0);
        chk("t6_spd0", 32'(bus.frwrd_spd), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd1);

        // Random traffic.
        repeat (3000) begin
            step("rnd",
                 $urandom_range(0, 3) == 0,
                 1'($urandom),
                 12'($urandom),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
